kb_game_mapper: RTL and testbench

//  Parametrised PS/2 scan-code-set-2 to game-control decoder for NUM_PLAYERS x KEYS_PER_PLAYER keys.

---
 rtl/kb_game_mapper.sv | 178 +++++++++++++++++
 tb/tb_kb_game_mapper.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/kb_game_mapper.sv
// kb_game_mapper: PS/2 scan-code-set-2 decoder that turns the byte stream from
// the PS/2 receiver into per-player game-control key levels and press pulses.
// Handles E0 (extended) and F0 (break) prefixes, skips the E1 pause sequence,
// and clears all keys on keyboard BAT results (0xAA / 0xFC).
//
// Optional feature macro: KB_MAPPER_TIMEOUT_EN
//   Defined   - a stalled prefix (EXT/BRK/EXT_BRK/SKIP with no byte for
//               TIMEOUT_CYCLES clocks) is abandoned: FSM returns to IDLE and
//               seq_err pulses once; key levels are left alone.
//   Undefined - prefix states wait indefinitely for the next byte.
`timescale 1ns/1ps

module kb_game_mapper #(
  parameter int NUM_PLAYERS     = 2,
  parameter int KEYS_PER_PLAYER = 5,
  // Entry i = KEYMAP[9*i +: 9] = {ext, code}; per player: up, down, left, right, shoot.
  parameter logic [9*NUM_PLAYERS*KEYS_PER_PLAYER-1:0] KEYMAP =
    {9'h04C, 9'h174, 9'h16B, 9'h172, 9'h175, 9'h03B, 9'h023, 9'h01C, 9'h01B, 9'h01D},
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [7:0]                             rx_data,
  input  logic                                   rx_done_tick,
  input  logic                                   clear,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] keys,
  output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] press_pulse,
  output logic                                   seq_err
);

  localparam int NKEYS = NUM_PLAYERS * KEYS_PER_PLAYER;

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE = 8'hE1;
  localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
  localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;

  // The pause make sequence is E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t           state;
  logic [2:0]       skip_cnt;
  logic [NKEYS-1:0] match;
  logic             ext_sel;
  logic             is_prefix;

  // Reject configurations that would make the decoder meaningless.
  if (NKEYS < 1) begin : g_bad_nkeys
    $error("kb_game_mapper: NUM_PLAYERS*KEYS_PER_PLAYER must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("kb_game_mapper: TIMEOUT_CYCLES must be at least 1");
  end

  // Which keymap entries match the current byte, given the extended flag implied by the state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    ext_sel   = (state == S_EXT) || (state == S_EXT_BRK);
    is_prefix = (rx_data == BYTE_EXT) || (rx_data == BYTE_BRK);
    match     = '0;
    for (int i = 0; i < NKEYS; i++) begin
      match[i] = (KEYMAP[9*i +: 9] == {ext_sel, rx_data});
    end
  end

`ifdef KB_MAPPER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Prefix FSM, key level register and one-cycle pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      skip_cnt    <= '0;
      keys        <= '0;
      press_pulse <= '0;
      seq_err     <= 1'b0;
`ifdef KB_MAPPER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in this
      // block to the same register (clear below) deliberately overrides earlier ones.
      press_pulse <= '0;
      seq_err     <= 1'b0;

      if (rx_done_tick) begin
`ifdef KB_MAPPER_TIMEOUT_EN
        tmo_cnt <= '0;
`endif
        case (state)
          S_IDLE: begin
            if (rx_data == BYTE_EXT) begin
              state <= S_EXT;
            end else if (rx_data == BYTE_BRK) begin
              state <= S_BRK;
            end else if (rx_data == BYTE_PAUSE) begin
              state    <= S_SKIP;
              skip_cnt <= PAUSE_TAIL;
            end else if (rx_data == BYTE_BAT_OK) begin
              keys <= '0;
            end else if (rx_data == BYTE_BAT_FAIL) begin
              keys    <= '0;
              seq_err <= 1'b1;
            end else begin
              keys        <= keys | match;
              press_pulse <= match & ~keys;
            end
          end

          S_EXT: begin
            if (rx_data == BYTE_BRK) begin
              state <= S_EXT_BRK;
            end else if (rx_data == BYTE_EXT) begin
              seq_err <= 1'b1;
            end else begin
              state       <= S_IDLE;
              keys        <= keys | match;
              press_pulse <= match & ~keys;
            end
          end

          S_BRK, S_EXT_BRK: begin
            state <= S_IDLE;
            if (is_prefix) begin
              seq_err <= 1'b1;
            end else begin
              keys <= keys & ~match;
            end
          end

          S_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) begin
              state <= S_IDLE;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
`ifdef KB_MAPPER_TIMEOUT_EN
      else if (state != S_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state    <= S_IDLE;
          skip_cnt <= '0;
          seq_err  <= 1'b1;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif

      // Clear wins over any same-cycle make/break; the FSM still consumed the byte above.
      if (clear) begin
        keys        <= '0;
        press_pulse <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kb_game_mapper.sv
// tb_kb_game_mapper: directed test of kb_game_mapper with the default keymap.
// Keymap index: 0=1D 1=1B 2=1C 3=23 4=3B 5=E0 75 6=E0 72 7=E0 6B 8=E0 74 9=4C.
`timescale 1ns/1ps

module tb_kb_game_mapper;

  localparam int NK = 10;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done_tick;
  logic          clear;
  logic [NK-1:0] keys;
  logic [NK-1:0] press_pulse;
  logic          seq_err;

  int n_tests;
  int n_fail;

  kb_game_mapper #(
    .NUM_PLAYERS     (2),
    .KEYS_PER_PLAYER (5),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .clear        (clear),
    .keys         (keys),
    .press_pulse  (press_pulse),
    .seq_err      (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the falling edge after the capturing rising edge,
  // where the registered results of this byte are visible.
  task automatic send(input logic [7:0] b, input logic clr = 1'b0);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    clear        = clr;
    @(negedge clk);
    rx_done_tick = 1'b0;
    clear        = 1'b0;
    rx_data      = 8'h00;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    clear        = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_keys",  32'(keys),        32'h0);
    check("reset_pulse", 32'(press_pulse), 32'h0);
    check("reset_err",   32'(seq_err),     32'h0);
    reset = 1'b1;

    // 1: make and typematic repeat
    send(8'h1D);
    check("make_1d_keys",  32'(keys),        32'h001);
    check("make_1d_pulse", 32'(press_pulse), 32'h001);
    send(8'h1D);
    check("repeat_1d_keys",  32'(keys),        32'h001);
    check("repeat_1d_pulse", 32'(press_pulse), 32'h000);

    // 2: break, extended make/break, unextended alias
    send(8'hF0);
    check("brk_prefix_keys", 32'(keys), 32'h001);
    send(8'h1D);
    check("break_1d_keys", 32'(keys), 32'h000);
    send(8'hE0);
    send(8'h75);
    check("ext_make_keys",  32'(keys),        32'h020);
    check("ext_make_pulse", 32'(press_pulse), 32'h020);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ext_break_keys", 32'(keys), 32'h000);
    send(8'h75);
    check("plain_75_keys",  32'(keys),        32'h000);
    check("plain_75_pulse", 32'(press_pulse), 32'h000);

    // 3: pause sequence is skipped without touching held keys
    send(8'h1D);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_keys", 32'(keys),    32'h001);
    check("pause_err",  32'(seq_err), 32'h0);
    send(8'h3B);
    check("after_pause_keys",  32'(keys),        32'h011);
    check("after_pause_pulse", 32'(press_pulse), 32'h010);

    // 4: clear beats a same-cycle make
    send(8'h1B);
    send(8'hE0);
    send(8'h6B);
    check("held_keys", 32'(keys), 32'h093);
    send(8'h23, 1'b1);
    check("clear_keys",  32'(keys),        32'h000);
    check("clear_pulse", 32'(press_pulse), 32'h000);
    send(8'h23);
    check("post_clear_keys",  32'(keys),        32'h008);
    check("post_clear_pulse", 32'(press_pulse), 32'h008);

    // BAT results
    send(8'hAA);
    check("bat_ok_keys", 32'(keys),    32'h000);
    check("bat_ok_err",  32'(seq_err), 32'h0);
    send(8'h1D);
    send(8'hFC);
    check("bat_fail_keys", 32'(keys),    32'h000);
    check("bat_fail_err",  32'(seq_err), 32'h1);

    // 5: protocol anomalies
    send(8'h1D);
    send(8'hE0);
    send(8'hF0);
    check("ebrk_no_err", 32'(seq_err), 32'h0);
    send(8'hF0);
    check("ebrk_f0_err",  32'(seq_err), 32'h1);
    check("ebrk_f0_keys", 32'(keys),    32'h001);
    send(8'h1B);
    check("idle_after_err_keys",  32'(keys),        32'h003);
    check("idle_after_err_pulse", 32'(press_pulse), 32'h002);
    check("err_one_cycle",        32'(seq_err),     32'h0);
    send(8'hE0);
    send(8'hE0);
    check("ext_e0_err", 32'(seq_err), 32'h1);
    send(8'h75);
    check("ext_kept_keys", 32'(keys), 32'h023);

    // Reset mid-prefix
    send(8'hE0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midpfx_reset_keys", 32'(keys), 32'h000);
    reset = 1'b1;
    send(8'h74);
    check("midpfx_74_keys", 32'(keys), 32'h000);

    // Reset mid-SKIP
    send(8'hE1);
    send(8'h14);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send(8'h1D);
    check("midskip_1d_keys", 32'(keys), 32'h001);

    // 6: timeout behaviour
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("pre_tmo_clear_keys", 32'(keys), 32'h000);
    send(8'hF0);
`ifdef KB_MAPPER_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("tmo_early_err", 32'(seq_err), 32'h0);
    @(negedge clk);
    check("tmo_err", 32'(seq_err), 32'h1);
    send(8'h1D);
    check("tmo_make_keys", 32'(keys), 32'h001);
`else
    repeat (40) @(negedge clk);
    check("no_tmo_err", 32'(seq_err), 32'h0);
    send(8'h1D);
    check("no_tmo_break_keys", 32'(keys), 32'h000);
    send(8'h1D);
    check("no_tmo_make_keys", 32'(keys), 32'h001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
